// File: rtl/obb_collision_scanner.sv
// Body table plus sequential separating-axis scanner over every unordered pair of active slots.
// Colliding pairs are reported as (lower, higher) index events on a valid/ready stream.
module obb_collision_scanner #(
    parameter int unsigned N_BODIES  = 8,
    parameter int unsigned POS_W     = 32,
    parameter int unsigned POS_FRAC  = 24,
    parameter int unsigned AXIS_W    = 16,
    parameter int unsigned AXIS_FRAC = 14,
    parameter int unsigned DIM_W     = 8,
    localparam int unsigned IDX_W    = (N_BODIES > 2) ? $clog2(N_BODIES) : 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic                     wr_active,
    input  logic signed [POS_W-1:0]  wr_pos_x,
    input  logic signed [POS_W-1:0]  wr_pos_y,
    input  logic signed [DIM_W-1:0]  wr_width,
    input  logic signed [DIM_W-1:0]  wr_height,
    input  logic signed [AXIS_W-1:0] wr_u_x,
    input  logic signed [AXIS_W-1:0] wr_u_y,
    input  logic signed [AXIS_W-1:0] wr_v_x,
    input  logic signed [AXIS_W-1:0] wr_v_y,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [IDX_W-1:0]         evt_a,
    output logic [IDX_W-1:0]         evt_b,
    output logic [15:0]              hit_count
);

    localparam int unsigned D_W   = POS_W + 1;
    localparam int unsigned DL_W  = D_W + AXIS_W + 1;
    localparam int unsigned AL_W  = 2 * AXIS_W + 1;
    localparam int unsigned R_W   = DIM_W + AL_W + 1;
    localparam int unsigned CMP_W = POS_W + AXIS_W + DIM_W + 2;
    localparam int unsigned SH    = (POS_FRAC - AXIS_FRAC) - 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_AXIS = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [N_BODIES-1:0]      active;
    logic signed [POS_W-1:0]  pos_x  [N_BODIES];
    logic signed [POS_W-1:0]  pos_y  [N_BODIES];
    logic signed [DIM_W-1:0]  width  [N_BODIES];
    logic signed [DIM_W-1:0]  height [N_BODIES];
    logic signed [AXIS_W-1:0] u_x    [N_BODIES];
    logic signed [AXIS_W-1:0] u_y    [N_BODIES];
    logic signed [AXIS_W-1:0] v_x    [N_BODIES];
    logic signed [AXIS_W-1:0] v_y    [N_BODIES];

    logic [2:0]               state;
    logic [2:0]               state_nxt;
    logic                     pair_adv;
    logic [IDX_W-1:0]         pair_i;
    logic [IDX_W-1:0]         pair_j;
    logic [IDX_W-1:0]         nxt_i;
    logic [IDX_W-1:0]         nxt_j;
    logic                     last_pair;
    logic [1:0]               axis_k;
    logic signed [D_W-1:0]    dx_q;
    logic signed [D_W-1:0]    dy_q;
    logic signed [AXIS_W-1:0] ax_x;
    logic signed [AXIS_W-1:0] ax_y;
    logic signed [DL_W-1:0]   d_l;
    logic [DL_W-1:0]          d_mag;
    logic [R_W-1:0]           ext_a;
    logic [R_W-1:0]           ext_b;
    logic                     separated;

    // |p . L| at full Q4.28 precision
    function automatic logic [AL_W-1:0] proj_mag(input logic signed [AXIS_W-1:0] px,
                                                 input logic signed [AXIS_W-1:0] py,
                                                 input logic signed [AXIS_W-1:0] lx,
                                                 input logic signed [AXIS_W-1:0] ly);
        logic signed [AL_W-1:0] s;
        s = AL_W'(px) * AL_W'(lx) + AL_W'(py) * AL_W'(ly);
        return s[AL_W-1] ? AL_W'(-s) : AL_W'(s);
    endfunction

    // Full extent projected onto L: |w|*|u.L| + |h|*|v.L|
    function automatic logic [R_W-1:0] extent(input logic signed [DIM_W-1:0]  w,
                                              input logic signed [DIM_W-1:0]  h,
                                              input logic signed [AXIS_W-1:0] ux,
                                              input logic signed [AXIS_W-1:0] uy,
                                              input logic signed [AXIS_W-1:0] vx,
                                              input logic signed [AXIS_W-1:0] vy,
                                              input logic signed [AXIS_W-1:0] lx,
                                              input logic signed [AXIS_W-1:0] ly);
        logic [DIM_W-1:0] w_mag;
        logic [DIM_W-1:0] h_mag;
        w_mag = w[DIM_W-1] ? DIM_W'(-w) : DIM_W'(w);
        h_mag = h[DIM_W-1] ? DIM_W'(-h) : DIM_W'(h);
        return R_W'(w_mag) * R_W'(proj_mag(ux, uy, lx, ly))
             + R_W'(h_mag) * R_W'(proj_mag(vx, vy, lx, ly));
    endfunction

    // Test axis for this cycle: uA, vA, uB, vB
    always_comb begin
        ax_x = u_x[pair_i];
        ax_y = u_y[pair_i];
        case (axis_k)
            2'd1:    begin ax_x = v_x[pair_i]; ax_y = v_y[pair_i]; end
            2'd2:    begin ax_x = u_x[pair_j]; ax_y = u_y[pair_j]; end
            2'd3:    begin ax_x = v_x[pair_j]; ax_y = v_y[pair_j]; end
            default: begin ax_x = u_x[pair_i]; ax_y = u_y[pair_i]; end
        endcase
    end

    // Compared at Q38 scale: |d.L| against half-extent sum, so no bits are rounded away
    always_comb begin
        d_l       = DL_W'(dx_q) * DL_W'(ax_x) + DL_W'(dy_q) * DL_W'(ax_y);
        d_mag     = d_l[DL_W-1] ? DL_W'(-d_l) : DL_W'(d_l);
        ext_a     = extent(width[pair_i], height[pair_i], u_x[pair_i], u_y[pair_i],
                           v_x[pair_i], v_y[pair_i], ax_x, ax_y);
        ext_b     = extent(width[pair_j], height[pair_j], u_x[pair_j], u_y[pair_j],
                           v_x[pair_j], v_y[pair_j], ax_x, ax_y);
        separated = CMP_W'(d_mag) > ((CMP_W'(ext_a) + CMP_W'(ext_b)) << SH);
    end

    always_comb begin
        last_pair = (pair_i == IDX_W'(N_BODIES - 2)) && (pair_j == IDX_W'(N_BODIES - 1));
        if (pair_j == IDX_W'(N_BODIES - 1)) begin
            nxt_i = pair_i + IDX_W'(1);
            nxt_j = pair_i + IDX_W'(2);
        end else begin
            nxt_i = pair_i;
            nxt_j = pair_j + IDX_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pair_adv  = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (!active[pair_i] || !active[pair_j]) begin
                    pair_adv  = 1'b1;
                    state_nxt = last_pair ? S_DONE : S_LOAD;
                end else begin
                    state_nxt = S_AXIS;
                end
            end
            S_AXIS: begin
                if (separated) begin
                    pair_adv  = 1'b1;
                    state_nxt = last_pair ? S_DONE : S_LOAD;
                end else if (axis_k == 2'd3) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (evt_ready) begin
                    pair_adv  = 1'b1;
                    state_nxt = last_pair ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            evt_valid <= 1'b0;
            evt_a     <= '0;
            evt_b     <= '0;
            hit_count <= '0;
            pair_i    <= '0;
            pair_j    <= IDX_W'(1);
            axis_k    <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            active    <= '0;
        end else begin
            busy      <= (state_nxt != S_IDLE);
            done      <= (state == S_DONE);
            evt_valid <= (state_nxt == S_EMIT);
            if (state == S_IDLE && start) begin
                hit_count <= '0;
                pair_i    <= '0;
                pair_j    <= IDX_W'(1);
            end
            if (pair_adv) begin
                pair_i <= nxt_i;
                pair_j <= nxt_j;
            end
            if (state == S_LOAD) begin
                dx_q   <= D_W'(pos_x[pair_j]) - D_W'(pos_x[pair_i]);
                dy_q   <= D_W'(pos_y[pair_j]) - D_W'(pos_y[pair_i]);
                axis_k <= '0;
            end
            if (state == S_AXIS) axis_k <= axis_k + 2'd1;
            if (state == S_AXIS && state_nxt == S_EMIT) begin
                evt_a <= pair_i;
                evt_b <= pair_j;
            end
            if (state == S_EMIT && evt_ready && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (wr_en && state == S_IDLE) active[wr_idx] <= wr_active;
        end
    end

    // Geometry carries no reset; active gates every use of it
    always_ff @(posedge Clk) begin
        if (wr_en && state == S_IDLE) begin
            pos_x[wr_idx]  <= wr_pos_x;
            pos_y[wr_idx]  <= wr_pos_y;
            width[wr_idx]  <= wr_width;
            height[wr_idx] <= wr_height;
            u_x[wr_idx]    <= wr_u_x;
            u_y[wr_idx]    <= wr_u_y;
            v_x[wr_idx]    <= wr_v_x;
            v_y[wr_idx]    <= wr_v_y;
        end
    end

endmodule
